// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
// Compile with DIV_SIGNED_EN defined to make the top handle two's-complement operands.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Step-counter width: enough bits to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << bits) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor
// with a WIDTH+1 ripple of full adders, keep or restore based on the borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   minuend;
  logic [WIDTH:0]   subtrahend_n;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] carry;
  logic             unused_diff_msb;

  assign minuend      = {rem_in, bit_in};
  assign subtrahend_n = ~{1'b0, divisor};
  assign carry[0]     = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    fulladder u_fa (
      .a    (minuend[i]),
      .b    (subtrahend_n[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  // Carry out of a + ~b + 1 is the inverted borrow: set means minuend >= divisor.
  assign q_bit   = carry[WIDTH+1];
  // A kept difference is below the divisor, so its top bit is always zero.
  assign rem_out = q_bit ? diff[WIDTH-1:0] : minuend[WIDTH-1:0];
  assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell shared with the multiplier datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// DIV_SIGNED_EN selects two's-complement operands with sign fix-up on the final step.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // holds the dividend, shifted out as quotient bits enter
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[WIDTH-1]),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  assign step_quo = {quo_q[WIDTH-2:0], step_bit};

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  assign dvd_mag = dividend[WIDTH-1] ? WIDTH'(0) - dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? WIDTH'(0) - divisor  : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d     = '0;
          divisor_d = dvs_mag;
          dbz_d     = (divisor == '0);
`ifdef DIV_SIGNED_EN
          neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            state_d = DONE;
          end else begin
            quo_d   = dvd_mag;
            rem_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        quo_d = step_quo;
        rem_d = step_rem;
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef DIV_SIGNED_EN
          quo_d = neg_quo_q ? WIDTH'(0) - step_quo : step_quo;
          rem_d = neg_rem_q ? WIDTH'(0) - step_rem : step_rem;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
